prio_req_encoder: RTL and testbench

//  Parametrised, registered successor of the 8x3 priority encoder. Collects

---
 rtl/prio_req_pkg.sv | 14 +
 rtl/prio_req_encoder_ffs.sv | 26 ++
 rtl/prio_req_encoder.sv | 102 ++++++++++
 tb/tb_prio_req_encoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_req_pkg.sv
// prio_req_pkg: shared sizing helpers and types for the pending-request encoder.
// No ports. Optional build macro used by the slice: ROUND_ROBIN_EN.
package prio_req_pkg;

  localparam int MAX_N = 64;

  // Widest one-hot request vector the encoder can be built for.
  typedef logic [MAX_N-1:0] onehot_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_req_encoder_ffs.sv
// prio_ffs: combinational find-highest-set over an N-bit vector.
// Ports: vec (in, N), idx (out, IDX_W) highest set index, any (out) vec != 0.
module prio_ffs
  import prio_req_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prio_req_encoder.sv
// prio_req_encoder: sticky pending requests, granted one index per cycle
// on a valid/ready port. Fixed priority (highest index first) by default;
// define ROUND_ROBIN_EN for rotating priority with a last_idx register.
// Ports: clk, rst (sync, active-high), en_n (0=run, 1=freeze),
//   req[N] pulses in, out_valid/out_ready/out_idx handshake,
//   pend[N] status, req_dup pulse for a req hitting a pending bit.
module prio_req_encoder
  import prio_req_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_n,
  input  logic [N-1:0]     req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     pend,
  output logic             req_dup
);

  logic             slot_free;
  logic             load;
  logic             ffs_any;
  logic [IDX_W-1:0] ffs_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [N-1:0]     search_vec;
  logic [N-1:0]     load_mask;
  logic [N-1:0]     pend_nxt;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W:0]   unrot;

  // Rotate right by last_idx: bit last_idx lands at 0 (lowest
  // priority) and bit last_idx-1 lands at N-1 (highest).
  always_comb begin
    search_vec = (pend >> last_idx)
               | (pend << (N - int'(last_idx)));
  end

  // Undo the rotation: index = (ffs_idx + last_idx) mod N.
  always_comb begin
    unrot = {1'b0, ffs_idx} + {1'b0, last_idx};
    if (unrot >= (IDX_W+1)'(N)) begin
      unrot = unrot - (IDX_W+1)'(N);
    end
    sel_idx = unrot[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_idx <= IDX_W'(N - 1);
    end else if (load) begin
      last_idx <= sel_idx;
    end
  end
`else
  assign search_vec = pend;
  assign sel_idx    = ffs_idx;
`endif

  prio_ffs #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_ffs (
    .vec (search_vec),
    .idx (ffs_idx),
    .any (ffs_any)
  );

  assign slot_free = !out_valid | out_ready;
  assign load      = !en_n & slot_free & ffs_any;

  assign load_mask = load ? ({{(N-1){1'b0}}, 1'b1} << sel_idx)
                          : '0;

  // OR-ing req after the clear lets a same-cycle set win.
  assign pend_nxt  = en_n ? pend
                          : ((pend & ~load_mask) | req);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      req_dup   <= 1'b0;
    end else begin
      pend    <= pend_nxt;
      req_dup <= !en_n & (|(req & pend & ~load_mask));
      if (load) begin
        out_valid <= 1'b1;
        out_idx   <= sel_idx;
      end else if (slot_free) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_req_encoder.sv
// tb_prio_req_encoder: directed and random checks of prio_req_encoder
// against a behavioural model built from the grant rules.
module tb_prio_req_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         en_n;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic [N-1:0] pend;
  logic         req_dup;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] m_pend;
  logic         m_valid;
  logic         m_dup;
  int           m_idx;
  int           m_last;

  prio_req_encoder #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_n      (en_n),
    .req       (req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .pend      (pend),
    .req_dup   (req_dup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit has(input logic [N-1:0] v, input int c);
    return ((v >> c) & {{(N-1){1'b0}}, 1'b1}) != '0;
  endfunction

  // Next state from the rules: pick by priority order, clear the
  // picked bit, OR in requests, flag requests hitting pending bits.
  task automatic model_step();
    bit           slot;
    int           pick;
    logic [N-1:0] mask;
    if (rst) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_idx   = 0;
      m_dup   = 1'b0;
      m_last  = N - 1;
    end else begin
      slot = !m_valid || out_ready;
      pick = -1;
      if (!en_n && slot) begin
`ifdef ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last - k + N) % N;
          if (pick < 0 && has(m_pend, c)) pick = c;
        end
`else
        for (int c = N - 1; c >= 0; c--) begin
          if (pick < 0 && has(m_pend, c)) pick = c;
        end
`endif
      end
      mask = (pick >= 0) ? N'(1) << pick : '0;
      if (!en_n) begin
        m_dup  = (req & m_pend & ~mask) != '0;
        m_pend = (m_pend & ~mask) | req;
      end else begin
        m_dup = 1'b0;
      end
      if (pick >= 0) begin
        m_valid = 1'b1;
        m_idx   = pick;
        m_last  = pick;
      end else if (slot) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("valid", 64'(out_valid), 64'(m_valid));
    chk("idx", 64'(out_idx), 64'(m_idx));
    chk("pend", 64'(pend), 64'(m_pend));
    chk("dup", 64'(req_dup), 64'(m_dup));
  endtask

  initial begin
    int exp2 [4];
    int prev;
    exp2 = '{7, 5, 2, 0};

    // 1: reset with all requests asserted
    rst = 1'b1; en_n = 1'b0; out_ready = 1'b0; req = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_pend", 64'(pend), 64'h0);
      chk("rst_valid", 64'(out_valid), 64'h0);
      chk("rst_idx", 64'(out_idx), 64'h0);
    end
    rst = 1'b0; req = '0; out_ready = 1'b1;
    cyc();

    // 2: fixed-priority drain of 1010_0101
    req = 8'b1010_0101;
    cyc();
    req = '0;
`ifndef ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("drain_v", 64'(out_valid), 64'h1);
      chk("drain_idx", 64'(out_idx), 64'(exp2[i]));
    end
`else
    for (int i = 0; i < 4; i++) cyc();
`endif
    cyc();
    chk("drain_end", 64'(out_valid), 64'h0);

    // 3: backpressure holds the presented index
    out_ready = 1'b0; req = 8'h08;
    cyc();
    req = '0;
    cyc();
    req = 8'h40;
    cyc();
    req = '0;
    cyc();
    chk("bp_hold", 64'(out_idx), 64'h3);
    chk("bp_hold_v", 64'(out_valid), 64'h1);
    out_ready = 1'b1;
    cyc();
    chk("bp_next", 64'(out_idx), 64'h6);
    cyc();
    chk("bp_end", 64'(out_valid), 64'h0);

    // 4a: set wins over clear -> idx 4 granted twice
    req = 8'h10;
    cyc();
    cyc();
    chk("sw_1", 64'(out_idx), 64'h4);
    req = '0;
    cyc();
    chk("sw_2", 64'(out_idx), 64'h4);
    chk("sw_2v", 64'(out_valid), 64'h1);
    cyc();
    chk("sw_end", 64'(out_valid), 64'h0);

    // 4b: duplicate pulse on an unloaded pending bit
    out_ready = 1'b0; req = 8'h80;
    cyc();
    req = '0;
    cyc();
    req = 8'h04;
    cyc();
    chk("dup_0", 64'(req_dup), 64'h0);
    cyc();
    chk("dup_1", 64'(req_dup), 64'h1);
    req = '0;
    cyc();
    chk("dup_off", 64'(req_dup), 64'h0);
    out_ready = 1'b1;
    cyc();
    chk("dup_g", 64'(out_idx), 64'h2);
    cyc();
    chk("dup_once", 64'(out_valid), 64'h0);

    // 5: freeze with idx 5 presented
    out_ready = 1'b0; req = 8'h20;
    cyc();
    req = '0;
    cyc();
    en_n = 1'b1; req = 8'h0F;
    cyc();
    cyc();
    chk("frz_idx", 64'(out_idx), 64'h5);
    chk("frz_pend", 64'(pend), 64'h0);
    out_ready = 1'b1;
    cyc();
    chk("frz_acc", 64'(out_valid), 64'h0);
    en_n = 1'b0; req = '0;
    cyc();
    chk("frz_lost", 64'(out_valid), 64'h0);
    chk("frz_lostp", 64'(pend), 64'h0);

    // reset overrides a pending handshake
    out_ready = 1'b0; req = 8'h01;
    cyc();
    req = '0;
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst_hs", 64'(out_valid), 64'h0);
    rst = 1'b0; out_ready = 1'b1;

    // 6: two requests held constantly
    req = 8'h82;
    cyc();
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      cyc();
`ifdef ROUND_ROBIN_EN
      chk("rr_alt", 64'(int'(out_idx) != prev), 64'h1);
      prev = int'(out_idx);
`else
      chk("fix_7", 64'(out_idx), 64'h7);
`endif
    end
    req = '0;
    for (int i = 0; i < 3; i++) cyc();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(63) == 0);
      en_n      = ($urandom_range(7) == 0);
      out_ready = 1'($urandom_range(1));
      req       = N'($urandom) & N'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
